// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multicycle signed ALU with start/done handshake and shift-add multiply
// Optional saturation of the WIDTH-bit arithmetic ops is enabled by defining ALU_MC_SAT_EN.
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     A_i,
    input  logic [WIDTH-1:0]     B_i,
    input  logic [2:0]           opSel,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_alu,
    output logic                 o_zero,
    output logic                 o_neg,
    output logic                 o_ovf
);
    localparam int W2  = 2 * WIDTH;
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t          r_state, w_state_nxt;
    logic [W2-1:0]   r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
    logic [W2-1:0]   r_acc, w_acc_nxt;
    logic            r_sign, w_sign_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_done, w_done_nxt;
    logic [W2-1:0]   r_alu, w_alu_nxt;
    logic            r_zero, w_zero_nxt;
    logic            r_neg, w_neg_nxt;
    logic            r_ovf, w_ovf_nxt;

    logic [WIDTH-1:0] w_sum, w_dif, w_nega, w_negb, w_ar;
    logic             w_ar_ovf, w_res_ovf;
    logic [W2-1:0]    w_res, w_acc_add, w_prod;

    // Single-cycle ops are evaluated straight from the inputs on the accepting edge.
    always_comb begin
        w_sum     = A_i + B_i;
        w_dif     = A_i - B_i;
        w_nega    = '0 - A_i;
        w_negb    = '0 - B_i;
        w_ar      = '0;
        w_ar_ovf  = 1'b0;
        w_res     = '0;
        w_res_ovf = 1'b0;
        case (opSel)
            3'd0: w_res = {{WIDTH{1'b0}}, A_i & B_i};
            3'd1: w_res = {{WIDTH{1'b0}}, A_i | B_i};
            3'd2: w_res = {{WIDTH{1'b0}}, ~B_i};
            3'd3: w_res = {{WIDTH{1'b0}}, A_i ^ B_i};
            3'd4: begin
                w_ar     = w_sum;
                w_ar_ovf = (A_i[MSB] == B_i[MSB]) && (w_sum[MSB] != A_i[MSB]);
            end
            3'd5: begin
                w_ar     = w_dif;
                w_ar_ovf = (A_i[MSB] != B_i[MSB]) && (w_dif[MSB] != A_i[MSB]);
            end
            3'd6: begin
                w_ar     = w_nega;
                w_ar_ovf = (A_i == MINV);
            end
            default: ;
        endcase
`ifdef ALU_MC_SAT_EN
        // Overflow direction follows A's sign for add/sub; negating the minimum always clips high.
        if (w_ar_ovf) begin
            if (opSel == 3'd6) w_ar = MAXV;
            else               w_ar = A_i[MSB] ? MINV : MAXV;
        end
`endif
        if (opSel[2] && (opSel != 3'd7)) begin
            w_res     = {{WIDTH{w_ar[MSB]}}, w_ar};
            w_res_ovf = w_ar_ovf;
        end
    end

    assign w_acc_add = r_acc + (r_mplier[0] ? r_mcand : {W2{1'b0}});
    assign w_prod    = r_sign ? ('0 - w_acc_add) : w_acc_add;

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_acc_nxt    = r_acc;
        w_sign_nxt   = r_sign;
        w_cnt_nxt    = r_cnt;
        w_done_nxt   = 1'b0;
        w_alu_nxt    = r_alu;
        w_zero_nxt   = r_zero;
        w_neg_nxt    = r_neg;
        w_ovf_nxt    = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (opSel == 3'd7) begin
                        w_mcand_nxt  = {{WIDTH{1'b0}}, (A_i[MSB] ? w_nega : A_i)};
                        w_mplier_nxt = B_i[MSB] ? w_negb : B_i;
                        w_sign_nxt   = A_i[MSB] ^ B_i[MSB];
                        w_acc_nxt    = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_MUL;
                    end else begin
                        w_alu_nxt  = w_res;
                        w_ovf_nxt  = w_res_ovf;
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_MUL: begin
                w_acc_nxt    = w_acc_add;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    w_alu_nxt   = w_prod;
                    w_ovf_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_done_nxt) begin
            w_zero_nxt = (w_alu_nxt == '0);
            w_neg_nxt  = w_alu_nxt[W2-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_alu    <= '0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_acc    <= w_acc_nxt;
            r_sign   <= w_sign_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_done_nxt;
            r_alu    <= w_alu_nxt;
            r_zero   <= w_zero_nxt;
            r_neg    <= w_neg_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    assign o_busy = (r_state == S_MUL);
    assign o_done = r_done;
    assign o_alu  = r_alu;
    assign o_zero = r_zero;
    assign o_neg  = r_neg;
    assign o_ovf  = r_ovf;
endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc against an integer-arithmetic reference model
module tb_alu_mc;
    localparam int W  = 8;
    localparam int W2 = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a_in, b_in;
    logic [2:0]    op_in;
    logic          o_busy, o_done, o_zero, o_neg, o_ovf;
    logic [W2-1:0] o_alu;

    int n_pass  = 0;
    int n_total = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .A_i     (a_in),
        .B_i     (b_in),
        .opSel   (op_in),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_alu   (o_alu),
        .o_zero  (o_zero),
        .o_neg   (o_neg),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W2-1:0] res, output logic ovf,
                                  output logic zero, output logic neg);
        longint sa, sb, r, mx, mn;
        logic [63:0] rv;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        mx  = (longint'(1) <<< (W - 1)) - 1;
        mn  = -(longint'(1) <<< (W - 1));
        r   = 0;
        ovf = 1'b0;
        res = '0;
        case (op)
            3'd0: res[W-1:0] = a & b;
            3'd1: res[W-1:0] = a | b;
            3'd2: res[W-1:0] = ~b;
            3'd3: res[W-1:0] = a ^ b;
            3'd7: begin
                r  = sa * sb;
                rv = r;
                res = rv[W2-1:0];
            end
            default: begin
                if (op == 3'd4)      r = sa + sb;
                else if (op == 3'd5) r = sa - sb;
                else                 r = -sa;
                ovf = (r > mx) || (r < mn);
                if (ovf) begin
`ifdef ALU_MC_SAT_EN
                    r = (r > mx) ? mx : mn;
`else
                    r = (r > mx) ? r - (longint'(1) <<< W) : r + (longint'(1) <<< W);
`endif
                end
                rv  = r;
                res = rv[W2-1:0];
            end
        endcase
        zero = (res == '0);
        neg  = res[W2-1];
    endfunction

    // Issues one op and waits (bounded) for o_done; inputs are scrambled after acceptance.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cnt);
        op_in = op; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        op_in = 3'($urandom);
        lat = 0;
        busy_cnt = 0;
        while (!o_done && lat < 4 * W) begin
            if (o_busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; op_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({o_busy, o_done, o_alu, o_zero, o_neg, o_ovf} !== '0)
            $display("FAIL reset_state: got busy=%b done=%b alu=%h z=%b n=%b v=%b, want all 0",
                     o_busy, o_done, o_alu, o_zero, o_neg, o_ovf);
        else n_pass++;
        start = 1'b1; op_in = 3'd1; a_in = 8'hFF; b_in = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        n_total++;
        if ({o_done, o_alu} !== '0)
            $display("FAIL reset_priority: got done=%b alu=%h, want done=0 alu=0", o_done, o_alu);
        else n_pass++;
    endtask

    task automatic test_directed();
        int            d_op[10] = '{4, 7, 7, 6, 2, 5, 4, 7, 5, 7};
        logic [W-1:0]  d_a[10]  = '{8'd100, 8'h80, 8'hFD, 8'h80, 8'h12, 8'h80, 8'h7F, 8'h7F, 8'h05, 8'h00};
        logic [W-1:0]  d_b[10]  = '{8'd50,  8'h80, 8'h05, 8'h33, 8'hFF, 8'h01, 8'h01, 8'h80, 8'h05, 8'h5A};
        logic [W2-1:0] er;
        logic          eo, ez, en;
        int            lat, bc, exp_lat;
        for (int i = 0; i < 10; i++) begin
            model(3'(d_op[i]), d_a[i], d_b[i], er, eo, ez, en);
            exp_lat = (d_op[i] == 7) ? W : 0;
            run_op(3'(d_op[i]), d_a[i], d_b[i], lat, bc);
            n_total++;
            if (lat != exp_lat || bc != exp_lat || o_busy !== 1'b0)
                $display("FAIL dir_timing[%0d]: got lat=%0d busy_cycles=%0d busy_at_done=%b, want lat=%0d busy_cycles=%0d busy_at_done=0",
                         i, lat, bc, o_busy, exp_lat, exp_lat);
            else n_pass++;
            n_total++;
            if ({o_alu, o_zero, o_neg, o_ovf} !== {er, ez, en, eo})
                $display("FAIL dir_result[%0d] op=%0d a=%h b=%h: got alu=%h z=%b n=%b v=%b, want alu=%h z=%b n=%b v=%b",
                         i, d_op[i], d_a[i], d_b[i], o_alu, o_zero, o_neg, o_ovf, er, ez, en, eo);
            else n_pass++;
            @(posedge clk); #1;
            n_total++;
            if (o_done !== 1'b0 || o_alu !== er)
                $display("FAIL dir_hold[%0d]: got done=%b alu=%h, want done=0 alu=%h", i, o_done, o_alu, er);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2:0]    op;
        logic [W-1:0]  a, b;
        logic [W2-1:0] er;
        logic          eo, ez, en;
        int            lat, bc;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = W'($urandom);
            b  = W'($urandom);
            model(op, a, b, er, eo, ez, en);
            run_op(op, a, b, lat, bc);
            n_total++;
            if (lat != ((op == 3'd7) ? W : 0) || {o_alu, o_zero, o_neg, o_ovf} !== {er, ez, en, eo})
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: got lat=%0d alu=%h z=%b n=%b v=%b, want alu=%h z=%b n=%b v=%b",
                         i, op, a, b, lat, o_alu, o_zero, o_neg, o_ovf, er, ez, en, eo);
            else n_pass++;
        end
    endtask

    task automatic test_mul_hold_start();
        logic [W2-1:0] er, er2;
        logic          eo, ez, en;
        int            lat, dones;
        model(3'd7, 8'hE7, 8'h6B, er, eo, ez, en);
        op_in = 3'd7; a_in = 8'hE7; b_in = 8'h6B; start = 1'b1;
        @(posedge clk); #1;
        lat = 0; dones = 0;
        while (!o_done && lat < 4 * W) begin
            a_in = W'($urandom); b_in = W'($urandom); op_in = 3'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (lat != W || o_alu !== er)
            $display("FAIL hold_start_mul: got lat=%0d alu=%h, want lat=%0d alu=%h", lat, o_alu, W, er);
        else n_pass++;
        op_in = 3'd1; a_in = 8'h51; b_in = 8'h0C;
        model(3'd1, 8'h51, 8'h0C, er2, eo, ez, en);
        @(posedge clk); #1;
        start = 1'b0;
        n_total++;
        if (o_done !== 1'b1 || o_alu !== er2)
            $display("FAIL accept_on_done: got done=%b alu=%h, want done=1 alu=%h", o_done, o_alu, er2);
        else n_pass++;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (o_done) dones++;
        end
        n_total++;
        if (dones != 0)
            $display("FAIL no_queued_start: got %0d extra done pulses, want 0", dones);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        int lat, bc, dones;
        run_op(3'd3, 8'hA5, 8'h0F, lat, bc);
        op_in = 3'd7; a_in = 8'hFD; b_in = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++;
        if ({o_busy, o_done, o_alu, o_zero, o_neg, o_ovf} !== '0)
            $display("FAIL reset_mid_mul: got busy=%b done=%b alu=%h z=%b n=%b v=%b, want all 0",
                     o_busy, o_done, o_alu, o_zero, o_neg, o_ovf);
        else n_pass++;
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (o_done || o_busy) dones++;
        end
        n_total++;
        if (dones != 0)
            $display("FAIL aborted_mul_activity: got %0d busy/done cycles, want 0", dones);
        else n_pass++;
        run_op(3'd0, 8'hF0, 8'h3C, lat, bc);
        n_total++;
        if (lat != 0 || o_alu !== 16'h0030)
            $display("FAIL post_reset_and: got lat=%0d alu=%h, want lat=0 alu=0030", lat, o_alu);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]    op;
        logic [W-1:0]  a, b;
        logic [W2-1:0] er;
        logic          eo, ez, en;
        for (int i = 0; i < 5; i++) begin
            op = 3'($urandom_range(0, 6));
            a  = W'($urandom);
            b  = W'($urandom);
            model(op, a, b, er, eo, ez, en);
            op_in = op; a_in = a; b_in = b; start = 1'b1;
            @(posedge clk); #1;
            n_total++;
            if (o_done !== 1'b1 || {o_alu, o_zero, o_neg, o_ovf} !== {er, ez, en, eo})
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got done=%b alu=%h z=%b n=%b v=%b, want done=1 alu=%h z=%b n=%b v=%b",
                         i, op, a, b, o_done, o_alu, o_zero, o_neg, o_ovf, er, ez, en, eo);
            else n_pass++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        n_total++;
        if (o_done !== 1'b0)
            $display("FAIL b2b_end: got done=%b, want 0", o_done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mul_hold_start();
        test_reset_mid_mul();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
